bf16_vector_accumulator: RTL and testbench



---
 rtl/bf16_pkg.sv | 26 ++
 rtl/bf16_fifo.sv | 43 ++++
 rtl/bf16_vector_accumulator.sv | 145 ++++++++++++++
 tb/tb_bf16_vector_accumulator.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bf16_pkg.sv
// Shared bfloat16 types, constants and accumulator FSM states
// used by the vector accumulator and its element buffer.
package bf16_pkg;

  typedef struct packed {
    logic       sign;
    logic [7:0] exp;
    logic [6:0] man;
  } bf16_t;

  localparam logic [15:0] BF16_POS_ZERO = 16'h0000;
  localparam logic [15:0] BF16_NEG_ZERO = 16'h8000;

  typedef enum logic [1:0] {
    LOAD,
    WAIT,
    EMIT
  } acc_state_t;

  // Buffered element: data plus end-of-vector marker.
  typedef struct packed {
    logic  last;
    bf16_t data;
  } elem_t;

endpackage

// File: rtl/bf16_fifo.sv
// Small synchronous FIFO, async active-high reset.
// Ports: clk_i, rst_i, push_i/data_i (write), pop_i/data_o (head), full_o, empty_o.
module bf16_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 17
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         push_i,
  input  logic [W-1:0] data_i,
  input  logic         pop_i,
  output logic [W-1:0] data_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [AW:0]  wr_q;
  logic [AW:0]  rd_q;
  logic [W-1:0] mem_q [DEPTH];

  // Extra MSB tells a full ring from an empty one.
  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[AW] != rd_q[AW]) &&
                   (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign data_o  = mem_q[rd_q[AW-1:0]];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (push_i && !full_o) wr_q <= wr_q + 1'b1;
      if (pop_i && !empty_o) rd_q <= rd_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_i && !full_o) mem_q[wr_q[AW-1:0]] <= data_i;
  end

endmodule

// File: rtl/bf16_vector_accumulator.sv
// Sequences a free-running multi-cycle bf16 adder to sum element vectors.
// Ports: clock/reset; in_* element stream (valid/ready/last);
// add_a/add_b operands, add_sum/add_ready adder result; out_* vector total + count.
module bf16_vector_accumulator
  import bf16_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_data,
  input  logic             in_last,
  output logic [15:0]      add_a,
  output logic [15:0]      add_b,
  input  logic [15:0]      add_sum,
  input  logic             add_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      out_data,
  output logic [CNT_W-1:0] out_count
);

  acc_state_t state_q, state_d;
  logic [15:0]      acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             last_q, last_d;
  logic [15:0]      add_a_q, add_a_d;
  logic [15:0]      add_b_q, add_b_d;
  logic             ov_q, ov_d;
  logic [15:0]      od_q, od_d;
  logic [CNT_W-1:0] oc_q, oc_d;

  elem_t            head;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;
  logic [CNT_W-1:0] cnt_inc;

  assign in_ready  = !full;
  assign push      = in_valid && !full;
  assign add_a     = add_a_q;
  assign add_b     = add_b_q;
  assign out_valid = ov_q;
  assign out_data  = od_q;
  assign out_count = oc_q;

  bf16_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     ($bits(elem_t))
  ) u_fifo (
    .clk_i   (clock),
    .rst_i   (reset),
    .push_i  (push),
    .data_i  ({in_last, in_data}),
    .pop_i   (pop),
    .data_o  (head),
    .full_o  (full),
    .empty_o (empty)
  );

  assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    add_a_d = add_a_q;
    add_b_d = add_b_q;
    ov_d    = ov_q;
    od_d    = od_q;
    oc_d    = oc_q;
    pop     = 1'b0;
    unique case (state_q)
      LOAD: begin
        // An add_ready with nothing buffered lets a stale pass go by.
        if (add_ready && !empty) begin
          add_a_d = acc_q;
          add_b_d = head.data;
          last_d  = head.last;
          pop     = 1'b1;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (add_ready) begin
          acc_d = add_sum;
          cnt_d = cnt_inc;
          if (last_q) begin
            ov_d    = 1'b1;
            od_d    = add_sum;
            oc_d    = cnt_inc;
            state_d = EMIT;
          end else if (!empty) begin
            // Chain straight into the next pass on the same pulse.
            add_a_d = add_sum;
            add_b_d = head.data;
            last_d  = head.last;
            pop     = 1'b1;
          end else begin
            state_d = LOAD;
          end
        end
      end
      EMIT: begin
        if (out_ready) begin
          ov_d    = 1'b0;
          acc_d   = BF16_POS_ZERO;
          cnt_d   = '0;
          state_d = LOAD;
        end
      end
      default: state_d = LOAD;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= LOAD;
      acc_q   <= BF16_POS_ZERO;
      cnt_q   <= '0;
      last_q  <= 1'b0;
      add_a_q <= '0;
      add_b_q <= '0;
      ov_q    <= 1'b0;
      od_q    <= '0;
      oc_q    <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      add_a_q <= add_a_d;
      add_b_q <= add_b_d;
      ov_q    <= ov_d;
      od_q    <= od_d;
      oc_q    <= oc_d;
    end
  end

endmodule

// File: tb/tb_bf16_vector_accumulator.sv
// Self-checking bench: accumulator paired with a behavioural
// free-running bf16 adder (4-cycle pass) and a real-valued reference.
module tb_bf16_vector_accumulator;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic        in_last;
  logic [15:0] add_a;
  logic [15:0] add_b;
  logic [15:0] add_sum;
  logic        add_ready;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic [7:0]  out_count;

  int n_checks = 0;
  int n_fail   = 0;
  int episodes = 0;
  logic ov_prev = 1'b0;
  logic [15:0] got_d [$];
  logic [7:0]  got_c [$];

  always #5 clock = ~clock;

  bf16_vector_accumulator #(
    .FIFO_DEPTH (4),
    .CNT_W      (8)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .add_a     (add_a),
    .add_b     (add_b),
    .add_sum   (add_sum),
    .add_ready (add_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_count (out_count)
  );

  function automatic real dec(input logic [15:0] h);
    real m;
    int  e;
    if (h[14:7] == 8'd0) return 0.0;
    m = 1.0 + real'(h[6:0]) / 128.0;
    e = int'(h[14:7]) - 127;
    while (e > 0) begin m = m * 2.0; e--; end
    while (e < 0) begin m = m / 2.0; e++; end
    return h[15] ? -m : m;
  endfunction

  function automatic logic [15:0] enc(input real r);
    real m;
    int  e;
    logic s;
    logic [6:0] man;
    if (r == 0.0) return 16'h0000;
    s = (r < 0.0);
    m = s ? -r : r;
    e = 127;
    while (m >= 2.0) begin m = m / 2.0; e++; end
    while (m < 1.0) begin m = m * 2.0; e--; end
    man = 7'($rtoi((m - 1.0) * 128.0));
    return {s, 8'(e), man};
  endfunction

  // Behavioural adder: pass of 4 cycles, ready on phase 3,
  // operands sampled on phase 0, result shown until next pass ends.
  wire adder_rst_n = ~reset;
  logic [1:0]  ph;
  logic [15:0] sum_q;
  assign add_ready = (ph == 2'd3);
  assign add_sum   = sum_q;

  always @(posedge clock or negedge adder_rst_n) begin
    if (!adder_rst_n) begin
      ph    <= 2'd0;
      sum_q <= 16'h0000;
    end else begin
      ph <= ph + 2'd1;
      if (ph == 2'd0) sum_q <= enc(dec(add_a) + dec(add_b));
    end
  end

  always @(negedge clock) begin
    if (reset) begin
      ov_prev = 1'b0;
    end else begin
      if (out_valid && !ov_prev) episodes++;
      ov_prev = out_valid;
      if (out_valid && out_ready) begin
        got_d.push_back(out_data);
        got_c.push_back(out_count);
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic timeout(input string nm);
    n_checks++;
    n_fail++;
    $display("FAIL %s: timed out", nm);
  endtask

  task automatic push(input logic [15:0] d, input logic l);
    int t = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    while (!in_ready && t < 1000) begin step(); t++; end
    if (!in_ready) timeout("push");
    step();
    in_valid = 1'b0;
  endtask

  task automatic wait_out(input string nm, input logic [15:0] ed,
                          input int ec);
    int t = 0;
    logic [15:0] dd;
    logic [7:0]  cc;
    while (got_d.size() == 0 && t < 4000) begin step(); t++; end
    if (got_d.size() == 0) begin
      timeout(nm);
    end else begin
      dd = got_d.pop_front();
      cc = got_c.pop_front();
      check({nm, " data"}, 32'(dd), 32'(ed));
      check({nm, " count"}, 32'(cc), 32'(ec));
    end
  endtask

  typedef struct {
    int          n;
    logic [15:0] el [3];
    logic [15:0] d;
    int          c;
  } vec_t;

  vec_t tbl [$];

  task automatic add_vec(input int n, input logic [15:0] e0,
                         input logic [15:0] e1, input logic [15:0] e2,
                         input logic [15:0] d, input int c);
    vec_t v;
    v.n = n;
    v.el[0] = e0;
    v.el[1] = e1;
    v.el[2] = e2;
    v.d = d;
    v.c = c;
    tbl.push_back(v);
  endtask

  task automatic reset_checks(input string nm);
    check({nm, " out_valid"}, 32'(out_valid), 32'd0);
    check({nm, " out_data"}, 32'(out_data), 32'h0);
    check({nm, " out_count"}, 32'(out_count), 32'd0);
    check({nm, " add_a"}, 32'(add_a), 32'h0);
    check({nm, " add_b"}, 32'(add_b), 32'h0);
    check({nm, " in_ready"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [15:0] hd;
    logic [7:0]  hc;
    logic [15:0] hist [4];
    int pushed;
    int pulses;
    int t;
    bit stable;
    bit acc;

    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = 16'h0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    repeat (3) step();
    reset_checks("reset");
    reset = 1'b0;
    step();

    add_vec(1, 16'h3F80, 16'h0, 16'h0, 16'h3F80, 1);
    add_vec(2, 16'h3F80, 16'h4000, 16'h0, 16'h4040, 2);
    add_vec(2, 16'h3F80, 16'hBF80, 16'h0, 16'h0000, 2);
    add_vec(1, 16'h3FC0, 16'h0, 16'h0, 16'h3FC0, 1);
    add_vec(3, 16'h4000, 16'h4040, 16'hC080, 16'h3F80, 3);

    foreach (tbl[i]) begin
      for (int k = 0; k < tbl[i].n; k++)
        push(tbl[i].el[k], k == tbl[i].n - 1);
      wait_out($sformatf("vec%0d", i), tbl[i].d, tbl[i].c);
      if (i == 0) begin
        repeat (10) step();
        check("single episodes", 32'(episodes), 32'd1);
      end
    end

    // Back-to-back chain: three elements buffered before the load pulse.
    t = 0;
    while (!add_ready && t < 20) begin step(); t++; end
    step();
    push(16'h3F80, 1'b0);
    push(16'h3F80, 1'b0);
    push(16'h4000, 1'b1);
    pulses = 0;
    foreach (hist[i]) hist[i] = 16'hFFFF;
    for (int c = 0; c < 60 && !out_valid; c++) begin
      if (add_ready) begin
        pulses++;
        step();
        if (pulses <= 4) hist[pulses-1] = add_a;
      end else begin
        step();
      end
    end
    check("chain pulses", 32'(pulses), 32'd4);
    check("chain a0", 32'(hist[0]), 32'h0000);
    check("chain a1", 32'(hist[1]), 32'h3F80);
    check("chain a2", 32'(hist[2]), 32'h4000);
    wait_out("chain", 16'h4080, 3);

    // Backpressure on the output while the input keeps pushing.
    out_ready = 1'b0;
    push(16'h3F80, 1'b1);
    t = 0;
    while (!out_valid && t < 100) begin step(); t++; end
    if (!out_valid) timeout("bp valid");
    hd = out_data;
    hc = out_count;
    check("bp total", 32'(hd), 32'h3F80);
    check("bp count", 32'(hc), 32'd1);
    pushed = 0;
    stable = 1'b1;
    for (int c = 0; c < 20; c++) begin
      if (pushed < 5) begin
        in_valid = 1'b1;
        in_data  = (pushed == 4) ? 16'h3F80 : 16'h4000;
        in_last  = (pushed == 4);
      end else begin
        in_valid = 1'b0;
      end
      acc = in_valid && in_ready;
      step();
      if (acc) pushed++;
      if (out_data != hd || out_count != hc || !out_valid) stable = 1'b0;
    end
    check("bp pushed", 32'(pushed), 32'd4);
    check("bp in_ready", 32'(in_ready), 32'd0);
    check("bp stable", 32'(stable), 32'd1);
    check("bp no handshake", 32'(got_d.size()), 32'd0);
    out_ready = 1'b1;
    t = 0;
    while (!in_ready && t < 200) begin step(); t++; end
    if (!in_ready) timeout("bp drain");
    step();
    in_valid = 1'b0;
    wait_out("bp held", 16'h3F80, 1);
    wait_out("bp next", 16'h4110, 5);

    // Reset while a pass is in flight.
    push(16'h4000, 1'b0);
    t = 0;
    while (add_b != 16'h4000 && t < 100) begin step(); t++; end
    if (add_b != 16'h4000) timeout("rst load");
    step();
    reset = 1'b1;
    step();
    reset_checks("midreset");
    reset = 1'b0;
    step();
    push(16'h4000, 1'b1);
    wait_out("rst", 16'h4000, 1);
    repeat (40) step();
    check("rst no stale", 32'(got_d.size()), 32'd0);

    // Count saturation.
    for (int k = 0; k < 260; k++) push(16'h0000, k == 259);
    wait_out("sat", 16'h0000, 255);

    // Random vectors against a real-valued reference sum.
    for (int v = 0; v < 20; v++) begin
      int  n;
      int  x;
      real s;
      n = $urandom_range(6, 1);
      s = 0.0;
      for (int k = 0; k < n; k++) begin
        x = int'($urandom_range(16)) - 8;
        s = s + real'(x);
        push(enc(real'(x)), k == n - 1);
        if ($urandom_range(3) == 0) step();
      end
      wait_out($sformatf("rand%0d", v), enc(s), n);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
